// File: rtl/tc_seq_pkg.sv
// ============================================================================
// Module : tc_seq_pkg
// Brief  : Shared types for the tensor-core GEMM tile sequencer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package tc_seq_pkg;

    localparam int IDX_W = 8;

    typedef logic [IDX_W-1:0] tile_idx_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } seq_state_t;

endpackage

`default_nettype wire

// File: rtl/tile_idx_stage.sv
// ============================================================================
// Module : tile_idx_stage
// Brief  : One tile-index register; wraps at limit-1 and reports the wrap.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tile_idx_stage #(
    parameter int W = 8
) (
    input  logic         CLK,
    input  logic         nRST,
    input  logic         i_inc,
    input  logic         i_clr,
    input  logic [W-1:0] i_limit,
    output logic [W-1:0] o_idx,
    output logic         o_wrap
);

    logic [W-1:0] r_idx;
    logic [W-1:0] w_last;

    // limit is never 0 while incrementing, so limit-1 cannot underflow in use
    assign w_last = i_limit - {{(W-1){1'b0}}, 1'b1};
    assign o_wrap = i_inc && (r_idx == w_last);
    assign o_idx  = r_idx;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_idx <= '0;
        end else if (i_clr) begin
            r_idx <= '0;
        end else if (i_inc) begin
            r_idx <= o_wrap ? '0 : r_idx + {{(W-1){1'b0}}, 1'b1};
        end
    end

endmodule

`default_nettype wire

// File: rtl/gemm_tile_sequencer.sv
// ============================================================================
// Module : gemm_tile_sequencer
// Brief  : Walks (m,n,k) GEMM tiles, k innermost, issuing one command per step.
//          Optional SEQ_PERF_EN adds stall/issue cycle counters.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module gemm_tile_sequencer
    import tc_seq_pkg::*;
#(
    parameter int IDX_W = 8
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             start,
    input  logic [IDX_W-1:0] m_tiles,
    input  logic [IDX_W-1:0] n_tiles,
    input  logic [IDX_W-1:0] k_tiles,
    input  logic             abort,
    output logic             cmd_valid,
    input  logic             cmd_ready,
    output logic [IDX_W-1:0] cmd_m,
    output logic [IDX_W-1:0] cmd_n,
    output logic [IDX_W-1:0] cmd_k,
    output logic             cmd_first_k,
    output logic             cmd_last_k,
    output logic             busy,
    output logic             done,
`ifdef SEQ_PERF_EN
    output logic [31:0]      stall_cycles,
    output logic [31:0]      issue_cycles,
`endif
    output logic             cfg_err
);

    seq_state_t       r_state;
    logic [IDX_W-1:0] r_m_tiles, r_n_tiles, r_k_tiles;
    logic             r_cfg_err;
    logic             w_issue, w_hs, w_cnt_ok, w_accept, w_clr;
    logic             w_k_wrap, w_n_wrap, w_m_wrap;

    assign w_issue  = (r_state == ISSUE);
    assign w_hs     = w_issue && cmd_ready;
    assign w_cnt_ok = (|m_tiles) && (|n_tiles) && (|k_tiles);
    assign w_accept = (r_state == IDLE) && start && w_cnt_ok;
    // Abort leaves indices at zero so the next job starts clean
    assign w_clr    = w_accept || (w_issue && abort);

    tile_idx_stage #(.W(IDX_W)) u_k (
        .CLK(CLK), .nRST(nRST), .i_inc(w_hs), .i_clr(w_clr),
        .i_limit(r_k_tiles), .o_idx(cmd_k), .o_wrap(w_k_wrap)
    );

    tile_idx_stage #(.W(IDX_W)) u_n (
        .CLK(CLK), .nRST(nRST), .i_inc(w_k_wrap), .i_clr(w_clr),
        .i_limit(r_n_tiles), .o_idx(cmd_n), .o_wrap(w_n_wrap)
    );

    tile_idx_stage #(.W(IDX_W)) u_m (
        .CLK(CLK), .nRST(nRST), .i_inc(w_n_wrap), .i_clr(w_clr),
        .i_limit(r_m_tiles), .o_idx(cmd_m), .o_wrap(w_m_wrap)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state   <= IDLE;
            r_m_tiles <= '0;
            r_n_tiles <= '0;
            r_k_tiles <= '0;
            r_cfg_err <= 1'b0;
        end else begin
            r_cfg_err <= (r_state == IDLE) && start && !w_cnt_ok;
            if (w_accept) begin
                r_m_tiles <= m_tiles;
                r_n_tiles <= n_tiles;
                r_k_tiles <= k_tiles;
            end
            case (r_state)
                IDLE:    if (w_accept) r_state <= ISSUE;
                ISSUE: begin
                    if (abort)         r_state <= IDLE;
                    else if (w_m_wrap) r_state <= DONE;
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign cmd_valid   = w_issue;
    assign busy        = (r_state != IDLE);
    assign done        = (r_state == DONE);
    assign cfg_err     = r_cfg_err;
    assign cmd_first_k = (cmd_k == '0);
    assign cmd_last_k  = (cmd_k == (r_k_tiles - {{(IDX_W-1){1'b0}}, 1'b1}));

`ifdef SEQ_PERF_EN
    logic [31:0] r_stall_cycles, r_issue_cycles;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_stall_cycles <= '0;
            r_issue_cycles <= '0;
        end else if (w_accept) begin
            r_stall_cycles <= '0;
            r_issue_cycles <= '0;
        end else if (w_issue) begin
            if (r_issue_cycles != 32'hFFFF_FFFF)
                r_issue_cycles <= r_issue_cycles + 32'd1;
            if (!cmd_ready && (r_stall_cycles != 32'hFFFF_FFFF))
                r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign issue_cycles = r_issue_cycles;
`endif

endmodule

`default_nettype wire

// File: tb/tb_gemm_tile_sequencer.sv
// ============================================================================
// Module : tb_gemm_tile_sequencer
// Brief  : Directed self-checking bench: table of jobs plus hand-written corners.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_gemm_tile_sequencer;

    logic       CLK = 1'b0;
    logic       nRST;
    logic       start;
    logic [7:0] m_tiles, n_tiles, k_tiles;
    logic       abort;
    logic       cmd_valid, cmd_ready;
    logic [7:0] cmd_m, cmd_n, cmd_k;
    logic       cmd_first_k, cmd_last_k, busy, done, cfg_err;
`ifdef SEQ_PERF_EN
    logic [31:0] stall_cycles, issue_cycles;
`endif

    always #5 CLK = ~CLK;

    gemm_tile_sequencer #(.IDX_W(8)) dut (
        .CLK(CLK), .nRST(nRST), .start(start),
        .m_tiles(m_tiles), .n_tiles(n_tiles), .k_tiles(k_tiles),
        .abort(abort), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_m(cmd_m), .cmd_n(cmd_n), .cmd_k(cmd_k),
        .cmd_first_k(cmd_first_k), .cmd_last_k(cmd_last_k),
        .busy(busy), .done(done),
`ifdef SEQ_PERF_EN
        .stall_cycles(stall_cycles), .issue_cycles(issue_cycles),
`endif
        .cfg_err(cfg_err)
    );

    typedef struct {
        int m;
        int n;
        int k;
        int stall;
    } job_t;

    int n_chk  = 0;
    int n_pass = 0;
    int hs_cnt = 0;
    int done_cnt = 0;

    always @(posedge CLK) begin
        if (cmd_valid && cmd_ready) hs_cnt <= hs_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // {valid, first_k, last_k, m, n, k}
    function automatic logic [31:0] pay();
        return {5'b0, cmd_valid, cmd_first_k, cmd_last_k, cmd_m, cmd_n, cmd_k};
    endfunction

    function automatic logic [31:0] exp_pay(input int m, input int n, input int k, input int kt);
        return {5'b0, 1'b1, (k == 0), (k == kt - 1), 8'(m), 8'(n), 8'(k)};
    endfunction

    task automatic run_job(input int m, input int n, input int k, input int stall);
        int hs0, d0;
        hs0 = hs_cnt;
        d0  = done_cnt;
        @(negedge CLK);
        m_tiles = 8'(m); n_tiles = 8'(n); k_tiles = 8'(k);
        start = 1'b1;
        cmd_ready = (stall == 0);
        @(negedge CLK);
        start = 1'b0;
        for (int mi = 0; mi < m; mi++)
            for (int ni = 0; ni < n; ni++)
                for (int ki = 0; ki < k; ki++) begin
                    for (int s = 0; s < stall; s++) begin
                        cmd_ready = 1'b0;
                        chk("stalled_payload", pay(), exp_pay(mi, ni, ki, k));
                        @(negedge CLK);
                    end
                    chk("cmd_payload", pay(), exp_pay(mi, ni, ki, k));
                    cmd_ready = 1'b1;
                    @(negedge CLK);
                end
        chk("done_pulse", {29'b0, done, cmd_valid, busy}, 32'b101);
        @(negedge CLK);
        chk("idle_after_done", {30'b0, done, busy}, 32'b0);
        chk("handshake_count", 32'(hs_cnt - hs0), 32'(m * n * k));
        chk("done_count", 32'(done_cnt - d0), 32'd1);
`ifdef SEQ_PERF_EN
        chk("issue_cycles", issue_cycles, 32'(m * n * k * (stall + 1)));
        chk("stall_cycles", stall_cycles, 32'(m * n * k * stall));
`endif
    endtask

    job_t jobs[4];
    int   hs0, d0;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        jobs[0] = '{m: 2, n: 2, k: 2, stall: 0};
        jobs[1] = '{m: 1, n: 1, k: 3, stall: 2};
        jobs[2] = '{m: 1, n: 3, k: 2, stall: 1};
        jobs[3] = '{m: 3, n: 1, k: 1, stall: 0};

        nRST = 1'b0; start = 1'b0; abort = 1'b0; cmd_ready = 1'b0;
        m_tiles = 8'd0; n_tiles = 8'd0; k_tiles = 8'd0;
        repeat (2) @(negedge CLK);
        chk("reset_outputs", {28'b0, cmd_valid, busy, done, cfg_err}, 32'b0);
        chk("reset_indices", {8'b0, cmd_m, cmd_n, cmd_k}, 32'b0);
        nRST = 1'b1;
        @(negedge CLK);
        chk("idle_after_reset", {30'b0, busy, cmd_valid}, 32'b0);

        foreach (jobs[i]) run_job(jobs[i].m, jobs[i].n, jobs[i].k, jobs[i].stall);

        // Zero tile count rejected, then a valid 1x1x1 job
        @(negedge CLK);
        m_tiles = 8'd1; n_tiles = 8'd1; k_tiles = 8'd0; start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        chk("cfg_err_pulse", {29'b0, cfg_err, busy, cmd_valid}, 32'b100);
        @(negedge CLK);
        chk("cfg_err_clears", {29'b0, cfg_err, busy, cmd_valid}, 32'b0);
        run_job(1, 1, 1, 0);

        // Abort concurrent with the 5th handshake of a 4x4x4 job
        hs0 = hs_cnt; d0 = done_cnt;
        @(negedge CLK);
        m_tiles = 8'd4; n_tiles = 8'd4; k_tiles = 8'd4; start = 1'b1; cmd_ready = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        repeat (4) @(negedge CLK);
        chk("abort_cycle_payload", pay(), exp_pay(0, 1, 0, 4));
        abort = 1'b1;
        @(negedge CLK);
        abort = 1'b0;
        chk("after_abort", {29'b0, cmd_valid, busy, done}, 32'b0);
        @(negedge CLK);
        chk("abort_hs_count", 32'(hs_cnt - hs0), 32'd5);
        chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
        run_job(1, 1, 1, 0);

        // Start while busy is ignored
        hs0 = hs_cnt; d0 = done_cnt;
        @(negedge CLK);
        m_tiles = 8'd2; n_tiles = 8'd1; k_tiles = 8'd1; start = 1'b1; cmd_ready = 1'b0;
        @(negedge CLK);
        chk("busy_first_cmd", pay(), exp_pay(0, 0, 0, 1));
        m_tiles = 8'd3; n_tiles = 8'd3; k_tiles = 8'd3; start = 1'b1; cmd_ready = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        chk("busy_second_cmd", pay(), exp_pay(1, 0, 0, 1));
        @(negedge CLK);
        chk("busy_job_done", {30'b0, done, cmd_valid}, 32'b10);
        repeat (2) @(negedge CLK);
        chk("busy_hs_count", 32'(hs_cnt - hs0), 32'd2);
        chk("busy_done_count", 32'(done_cnt - d0), 32'd1);

        // Asynchronous reset in the middle of a job
        @(negedge CLK);
        m_tiles = 8'd4; n_tiles = 8'd4; k_tiles = 8'd4; start = 1'b1; cmd_ready = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        repeat (3) @(negedge CLK);
        #2 nRST = 1'b0;
        #1;
        chk("async_reset_ctrl", {29'b0, cmd_valid, busy, done}, 32'b0);
        chk("async_reset_payload", pay(), {5'b0, 1'b0, 1'b1, 1'b0, 24'b0});
        @(negedge CLK);
        nRST = 1'b1;
        repeat (3) begin
            @(negedge CLK);
            chk("idle_after_async_reset", {30'b0, busy, cmd_valid}, 32'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
